display_scheduler: RTL and testbench

Shares the four-digit seven-segment display between three BCD sources and drives the display driver's `BCD_16bit` and `En_7seg` inputs. Source 0 is the background value, shown whenever no overlay is active. Sources 1 and 2 request the display through a req/gnt handshake. The block also applies a minimum linger time after an overlay releases, generates blink timing for flashing digits, and rejects non-BCD values before they reach the decoder.

---
 rtl/display_sched_pkg.sv | 24 ++
 rtl/display_scheduler_flash_timer.sv | 45 ++++
 rtl/display_scheduler.sv | 134 +++++++++++++
 tb/tb_display_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display scheduler: arbiter states,
// source indices and the BCD validity check.
package display_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWNED  = 2'd1,
    LINGER = 2'd2
  } state_e;

  localparam logic [1:0] SRC_BG  = 2'd0;
  localparam logic [1:0] SRC_OV1 = 2'd1;
  localparam logic [1:0] SRC_OV2 = 2'd2;

  function automatic logic bcd_valid16(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/display_scheduler_flash_timer.sv
// Blink phase generator: lit for FLASH_HALF cycles, dark for FLASH_HALF cycles.
// Dark while in reset; forced lit (and re-armed) whenever disabled or restarted.
module flash_timer #(
  parameter int FLASH_HALF = 25
) (
  input  logic clk_100Hz,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic lit
);

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] LAST = FW'(FLASH_HALF - 1);

  logic [FW-1:0] cnt_q, cnt_d;
  logic          lit_q, lit_d;

  always_comb begin
    cnt_d = cnt_q;
    lit_d = lit_q;
    if (restart || !enable) begin
      cnt_d = '0;
      lit_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      lit_d = ~lit_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lit_q <= lit_d;
    end
  end

  assign lit = lit_q;

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the seven-segment display between a background source and two
// req/gnt overlays, with post-release linger, blinking and BCD filtering.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int HOLD_TICKS = 200,
  parameter int FLASH_HALF = 25
) (
  input  logic        clk_100Hz,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  flash_req,
  input  logic [15:0] bcd0,
  input  logic [15:0] bcd1,
  input  logic [15:0] bcd2,
  output logic [2:0]  gnt,
  output logic [15:0] BCD_16bit,
  output logic        En_7seg,
  output logic        bad_bcd
);

  localparam int LW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [LW-1:0] LINGER_LOAD = LW'(HOLD_TICKS - 1);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          bad_q, bad_d;
  logic [2:0]    fl_q;
  logic [15:0]   sel;
  logic          flash_en, flash_restart, lit;

  // Source 0 never requests; its bit exists only for port symmetry.
  logic unused_req0;
  assign unused_req0 = req[0];

  // Whenever any overlay requests, the highest-priority one owns the display.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    unique case (state_q)
      IDLE, OWNED: begin
        if (req[2]) begin
          state_d = OWNED;
          owner_d = SRC_OV2;
        end else if (req[1]) begin
          state_d = OWNED;
          owner_d = SRC_OV1;
        end else if (state_q == OWNED) begin
          state_d = LINGER;
          lcnt_d  = LINGER_LOAD;
        end else begin
          owner_d = SRC_BG;
        end
      end
      LINGER: begin
        if (req[2]) begin
          state_d = OWNED;
          owner_d = SRC_OV2;
        end else if (req[1]) begin
          state_d = OWNED;
          owner_d = SRC_OV1;
        end else if (lcnt_q == '0) begin
          state_d = IDLE;
          owner_d = SRC_BG;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = SRC_BG;
      end
    endcase
  end

  always_comb begin
    unique case (owner_d)
      SRC_OV1: sel = bcd1;
      SRC_OV2: sel = bcd2;
      default: sel = bcd0;
    endcase
    bcd_d = bcd_q;
    bad_d = 1'b0;
    // Lingering shows the frozen value, so sources are not looked at.
    if (state_d != LINGER) begin
      if (bcd_valid16(sel)) bcd_d = sel;
      else                  bad_d = 1'b1;
    end
    gnt_d = 3'b001 << owner_d;
  end

  assign flash_en      = flash_req[owner_d];
  assign flash_restart = (owner_d != owner_q) || (flash_en && !fl_q[owner_d]);

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= SRC_BG;
      lcnt_q  <= '0;
      bcd_q   <= 16'h0000;
      gnt_q   <= 3'b001;
      bad_q   <= 1'b0;
      fl_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
      bcd_q   <= bcd_d;
      gnt_q   <= gnt_d;
      bad_q   <= bad_d;
      fl_q    <= flash_req;
    end
  end

  flash_timer #(
    .FLASH_HALF(FLASH_HALF)
  ) u_flash (
    .clk_100Hz(clk_100Hz),
    .rst_n    (rst_n),
    .restart  (flash_restart),
    .enable   (flash_en),
    .lit      (lit)
  );

  assign gnt       = gnt_q;
  assign BCD_16bit = bcd_q;
  assign bad_bcd   = bad_q;
  assign En_7seg   = lit;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed vector table, asynchronous reset check and randomized run against
// a priority/linger/blink reference model for display_scheduler.
module tb_display_scheduler;

  localparam int HT = 4;
  localparam int FH = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, fl;
  logic [15:0] b0, b1, b2;
  logic [2:0]  gnt;
  logic [15:0] bcd_out;
  logic        en, bad;

  int n_tests = 0;
  int n_fail  = 0;

  display_scheduler #(.HOLD_TICKS(HT), .FLASH_HALF(FH)) dut (
    .clk_100Hz(clk),
    .rst_n    (rst_n),
    .req      (req),
    .flash_req(fl),
    .bcd0     (b0),
    .bcd1     (b1),
    .bcd2     (b2),
    .gnt      (gnt),
    .BCD_16bit(bcd_out),
    .En_7seg  (en),
    .bad_bcd  (bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req, fl;
    logic [15:0] b0, b1, b2;
    logic [2:0]  gnt;
    logic [15:0] bcd;
    logic        en, bad;
  } vec_t;

  vec_t tbl[$];

  // Reference model: owner is the highest requesting overlay; otherwise a
  // released overlay lingers HT cycles; blink phase derived from age.
  int          m_owner, m_left, m_age;
  bit          m_ling;
  logic [15:0] m_shown;
  logic        m_bad, m_en;
  logic [2:0]  m_prev_fl;

  function automatic bit is_bcd(input logic [15:0] v);
    int x;
    x = int'(v);
    for (int k = 0; k < 4; k++) if (((x >> (4 * k)) & 15) > 9) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_age = 0; m_ling = 0;
    m_shown = 16'h0000; m_bad = 0; m_en = 0; m_prev_fl = 3'b000;
  endtask

  task automatic model_step();
    int          old_owner;
    logic [15:0] v;
    old_owner = m_owner;
    if (req[2]) begin m_owner = 2; m_ling = 0; end
    else if (req[1]) begin m_owner = 1; m_ling = 0; end
    else if (m_ling) begin
      if (m_left == 0) begin m_ling = 0; m_owner = 0; end
      else m_left = m_left - 1;
    end else if (m_owner != 0) begin
      m_ling = 1; m_left = HT - 1;
    end
    m_bad = 0;
    if (!m_ling) begin
      v = (m_owner == 2) ? b2 : (m_owner == 1) ? b1 : b0;
      if (is_bcd(v)) m_shown = v;
      else           m_bad = 1;
    end
    if (!fl[m_owner]) begin
      m_age = 0; m_en = 1;
    end else begin
      if (m_owner != old_owner || !m_prev_fl[m_owner]) m_age = 0;
      else m_age = m_age + 1;
      m_en = ((m_age / FH) % 2) == 0;
    end
    m_prev_fl = fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] rq, input logic [2:0] f, input logic [15:0] x0,
                     input logic [15:0] x1, input logic [15:0] x2, input logic [2:0] g,
                     input logic [15:0] v, input logic e, input logic bd);
    vec_t r;
    r.req = rq; r.fl = f; r.b0 = x0; r.b1 = x1; r.b2 = x2;
    r.gnt = g; r.bcd = v; r.en = e; r.bad = bd;
    tbl.push_back(r);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    add(3'b000, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b001, 16'h1234, 1, 0);
    for (int i = 0; i < 5; i++)
      add(3'b010, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b010, 16'h0930, 1, 0);
    for (int i = 0; i < 4; i++)
      add(3'b000, 3'b000, 16'h1234, 16'h0000, 16'h5555, 3'b010, 16'h0930, 1, 0);
    add(3'b000, 3'b000, 16'h1234, 16'h0000, 16'h5555, 3'b001, 16'h1234, 1, 0);
    add(3'b010, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b010, 16'h0930, 1, 0);
    add(3'b110, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b100, 16'h5555, 1, 0);
    add(3'b110, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b100, 16'h5555, 1, 0);
    add(3'b010, 3'b000, 16'h1234, 16'h0930, 16'h5555, 3'b010, 16'h0930, 1, 0);
    for (int i = 0; i < 10; i++)
      add(3'b100, 3'b100, 16'h1234, 16'h0930, 16'h5555, 3'b100, 16'h5555,
          (i < 3 || (i >= 6 && i < 9)) ? 1'b1 : 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add(3'b010, 3'b010, 16'h1234, 16'h0930, 16'h5555, 3'b010, 16'h0930,
          (i < 3) ? 1'b1 : 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add(3'b000, 3'b000, 16'h0042, 16'h0930, 16'h5555, 3'b010, 16'h0930, 1, 0);
    add(3'b000, 3'b000, 16'h0042, 16'h0930, 16'h5555, 3'b001, 16'h0042, 1, 0);
    add(3'b000, 3'b000, 16'h00A2, 16'h0930, 16'h5555, 3'b001, 16'h0042, 1, 1);
    add(3'b000, 3'b000, 16'h00A2, 16'h0930, 16'h5555, 3'b001, 16'h0042, 1, 1);
    add(3'b000, 3'b000, 16'h0043, 16'h0930, 16'h5555, 3'b001, 16'h0043, 1, 0);

    rst_n = 1'b0; req = 3'b000; fl = 3'b000;
    b0 = 16'h1234; b1 = 16'h0930; b2 = 16'h5555;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 32'(gnt), 32'h1);
    chk("reset bcd", 32'(bcd_out), 32'h0);
    chk("reset en", 32'(en), 32'h0);
    chk("reset bad", 32'(bad), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req; fl = tbl[i].fl;
      b0 = tbl[i].b0; b1 = tbl[i].b1; b2 = tbl[i].b2;
      tick();
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d bcd", i), 32'(bcd_out), 32'(tbl[i].bcd));
      chk($sformatf("vec%0d en", i), 32'(en), 32'(tbl[i].en));
      chk($sformatf("vec%0d bad", i), 32'(bad), 32'(tbl[i].bad));
    end

    // Asynchronous reset while lingering, then recovery.
    req = 3'b010; fl = 3'b010; b1 = 16'h0777; b0 = 16'h1234;
    tick(); tick();
    req = 3'b000;
    tick();
    chk("pre-reset linger gnt", 32'(gnt), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async gnt", 32'(gnt), 32'h1);
    chk("async bcd", 32'(bcd_out), 32'h0);
    chk("async en", 32'(en), 32'h0);
    chk("async bad", 32'(bad), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    fl = 3'b000;
    tick();
    chk("post-reset gnt", 32'(gnt), 32'h1);
    chk("post-reset bcd", 32'(bcd_out), 32'h1234);
    chk("post-reset en", 32'(en), 32'h1);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0)
        req = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) fl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) b0 = rand_bcd();
      if ($urandom_range(0, 2) == 0) b1 = rand_bcd();
      if ($urandom_range(0, 2) == 0) b2 = rand_bcd();
      tick();
      chk($sformatf("rnd%0d gnt", c), 32'(gnt), 32'(3'b001 << m_owner));
      chk($sformatf("rnd%0d bcd", c), 32'(bcd_out), 32'(m_shown));
      chk($sformatf("rnd%0d en", c), 32'(en), 32'(m_en));
      chk($sformatf("rnd%0d bad", c), 32'(bad), 32'(m_bad));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
